// File: rtl/led_breath_envelope.sv
// led_breath_envelope: breathing duty envelope (rise, hold high, fall, hold low) for the PWM stage
module led_breath_envelope #(
  parameter int WIDTH      = 5,
  parameter int PRESCALE   = 524288,
  parameter int HOLD_STEPS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [WIDTH-1:0] duty,
  output logic             duty_stb,
  output logic [2:0]       phase,
  output logic             cycle_done
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int HW = HOLD_STEPS > 0 ? $clog2(HOLD_STEPS + 1) : 1;
  localparam logic [WIDTH-1:0] MAX = '1;
  typedef enum logic [2:0] {IDLE = 3'd0, RISE = 3'd1, HOLD_HI = 3'd2, FALL = 3'd3, HOLD_LO = 3'd4} state_t;
  state_t state, state_n;
  logic [PW-1:0] ps, ps_n;
  logic [HW-1:0] hold, hold_n;
  logic [WIDTH-1:0] duty_n;
  logic stb_n, done_n, tick, hold_end;
  assign tick = ps == PW'(PRESCALE - 1);
  assign hold_end = hold == HW'(HOLD_STEPS - 1);
  assign phase = state;
  always_comb begin
    state_n = state;
    duty_n = duty;
    hold_n = hold;
    stb_n = 1'b0;
    done_n = 1'b0;
    ps_n = (state == IDLE || tick) ? '0 : ps + PW'(1);
    case (state)
      IDLE: begin
        duty_n = '0;
        if (enable) state_n = RISE;
      end
      RISE: begin
        // a falling enable takes priority over a coincident tick: fade out from the current duty
        if (!enable) state_n = FALL;
        else if (tick) begin
          duty_n = (duty == MAX) ? duty : duty + WIDTH'(1);
          stb_n = duty != MAX;
          if (duty >= MAX - WIDTH'(1)) state_n = (HOLD_STEPS == 0) ? FALL : HOLD_HI;
        end
      end
      HOLD_HI: begin
        if (!enable) begin
          state_n = FALL;
          hold_n = '0;
        end else if (tick) begin
          hold_n = hold_end ? '0 : hold + HW'(1);
          if (hold_end) state_n = FALL;
        end
      end
      FALL: begin
        if (tick) begin
          duty_n = (duty == '0) ? duty : duty - WIDTH'(1);
          stb_n = duty != '0;
          if (duty <= WIDTH'(1)) begin
            state_n = (HOLD_STEPS != 0) ? HOLD_LO : (enable ? RISE : IDLE);
            done_n = (HOLD_STEPS == 0) && enable;
          end
        end
      end
      HOLD_LO: begin
        if (!enable) begin
          state_n = IDLE;
          hold_n = '0;
        end else if (tick) begin
          hold_n = hold_end ? '0 : hold + HW'(1);
          if (hold_end) begin
            state_n = RISE;
            done_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      duty <= '0;
      duty_stb <= 1'b0;
      cycle_done <= 1'b0;
      ps <= '0;
      hold <= '0;
    end else begin
      state <= state_n;
      duty <= duty_n;
      duty_stb <= stb_n;
      cycle_done <= done_n;
      ps <= ps_n;
      hold <= hold_n;
    end
  end
endmodule

// File: tb/tb_led_breath_envelope.sv
// tb_led_breath_envelope: scoreboard bench for the breathing envelope, nominal and corner parameters
module tb_led_breath_envelope;
  logic clk = 1'b0, rst = 1'b0, en0 = 1'b0, en1 = 1'b0;
  logic [2:0] duty0, duty1, phase0, phase1;
  logic stb0, stb1, cd0, cd1;
  int cyc = 0, checks = 0, errors = 0;
  bit corner_done = 1'b0;
  typedef struct {int c; int d;} ev_t;
  ev_t q0[$], q1[$];
  int qc0[$], qc1[$];

  led_breath_envelope #(.WIDTH(3), .PRESCALE(4), .HOLD_STEPS(2)) u0 (
    .clk(clk), .rst(rst), .enable(en0), .duty(duty0), .duty_stb(stb0), .phase(phase0), .cycle_done(cd0));
  led_breath_envelope #(.WIDTH(3), .PRESCALE(1), .HOLD_STEPS(0)) u1 (
    .clk(clk), .rst(rst), .enable(en1), .duty(duty1), .duty_stb(stb1), .phase(phase1), .cycle_done(cd1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(int u, int c, int d);
    ev_t e;
    e.c = c;
    e.d = d;
    if (u == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic wait_cyc(int t);
    while (cyc < t) @(negedge clk);
  endtask

  always @(negedge clk) begin : mon0
    ev_t e;
    while (q0.size() > 0 && q0[0].c < cyc) begin
      checks++; errors++;
      $display("FAIL u0 strobe missing: none at cyc %0d, expected duty %0d", q0[0].c, q0[0].d);
      void'(q0.pop_front());
    end
    if (stb0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL u0 strobe extra: at cyc %0d duty %0d, expected none", cyc, duty0);
      end else begin
        e = q0.pop_front();
        chk("u0_stb_cyc", cyc, e.c);
        chk("u0_stb_duty", int'(duty0), e.d);
      end
    end
    while (qc0.size() > 0 && qc0[0] < cyc) begin
      checks++; errors++;
      $display("FAIL u0 cycle_done missing: none at cyc %0d", qc0[0]);
      void'(qc0.pop_front());
    end
    if (cd0) begin
      if (qc0.size() == 0) begin
        checks++; errors++;
        $display("FAIL u0 cycle_done extra: at cyc %0d, expected none", cyc);
      end else chk("u0_done_cyc", cyc, qc0.pop_front());
    end
  end

  always @(negedge clk) begin : mon1
    ev_t e;
    while (q1.size() > 0 && q1[0].c < cyc) begin
      checks++; errors++;
      $display("FAIL u1 strobe missing: none at cyc %0d, expected duty %0d", q1[0].c, q1[0].d);
      void'(q1.pop_front());
    end
    if (stb1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL u1 strobe extra: at cyc %0d duty %0d, expected none", cyc, duty1);
      end else begin
        e = q1.pop_front();
        chk("u1_stb_cyc", cyc, e.c);
        chk("u1_stb_duty", int'(duty1), e.d);
      end
    end
    while (qc1.size() > 0 && qc1[0] < cyc) begin
      checks++; errors++;
      $display("FAIL u1 cycle_done missing: none at cyc %0d", qc1[0]);
      void'(qc1.pop_front());
    end
    if (cd1) begin
      if (qc1.size() == 0) begin
        checks++; errors++;
        $display("FAIL u1 cycle_done extra: at cyc %0d, expected none", cyc);
      end else chk("u1_done_cyc", cyc, qc1.pop_front());
    end
  end

  initial begin : main
    int k, k2, k3;
    #1 rst = 1'b1;
    #2;
    chk("rst_duty", int'(duty0), 0);
    chk("rst_stb", int'(stb0), 0);
    chk("rst_phase", int'(phase0), 0);
    chk("rst_done", int'(cd0), 0);
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(5);
    k = cyc;
    en0 = 1'b1;
    for (int b = 0; b < 3; b++) begin
      for (int i = 1; i <= (b < 2 ? 7 : 4); i++) push(0, k + 72 * b + 1 + 4 * i, i);
      if (b < 2) begin
        for (int j = 1; j <= 7; j++) push(0, k + 72 * b + 37 + 4 * j, 7 - j);
        qc0.push_back(k + 72 * b + 73);
      end
    end
    for (int j = 1; j <= 4; j++) push(0, k + 161 + 4 * j, 4 - j);
    wait_cyc(k + 1);   chk("phase_rise", int'(phase0), 1);
    wait_cyc(k + 29);  chk("duty_max", int'(duty0), 7); chk("phase_hold_hi", int'(phase0), 2);
    wait_cyc(k + 37);  chk("phase_fall", int'(phase0), 3);
    wait_cyc(k + 65);  chk("duty_zero", int'(duty0), 0); chk("phase_hold_lo", int'(phase0), 4);
    wait_cyc(k + 73);  chk("phase_rerise", int'(phase0), 1);
    wait_cyc(k + 161); chk("duty_at_stop", int'(duty0), 4);
    en0 = 1'b0;
    wait_cyc(k + 162); chk("phase_stop_fall", int'(phase0), 3); chk("duty_kept", int'(duty0), 4);
    wait_cyc(k + 177); chk("phase_stop_hold_lo", int'(phase0), 4);
    wait_cyc(k + 178); chk("phase_stop_idle", int'(phase0), 0);
    wait_cyc(k + 180);
    k2 = cyc;
    en0 = 1'b1;
    for (int i = 1; i <= 7; i++) push(0, k2 + 1 + 4 * i, i);
    push(0, k2 + 41, 6);
    push(0, k2 + 45, 5);
    wait_cyc(k2 + 46); chk("duty_mid_fall", int'(duty0), 5); chk("phase_mid_fall", int'(phase0), 3);
    #1 rst = 1'b1;
    #1;
    chk("arst_duty", int'(duty0), 0);
    chk("arst_stb", int'(stb0), 0);
    chk("arst_phase", int'(phase0), 0);
    chk("arst_done", int'(cd0), 0);
    #1 rst = 1'b0;
    k3 = cyc;
    push(0, k3 + 5, 1);
    push(0, k3 + 9, 2);
    wait_cyc(k3 + 1);  chk("restart_phase", int'(phase0), 1);
    wait_cyc(k3 + 5);  chk("restart_duty1", int'(duty0), 1);
    wait_cyc(k3 + 9);  chk("restart_duty2", int'(duty0), 2);
    wait_cyc(k3 + 12);
    chk("corner_finished", int'(corner_done), 1);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("qc0_drained", qc0.size(), 0);
    chk("qc1_drained", qc1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : corner
    int c, p;
    wait_cyc(5);
    c = cyc;
    en1 = 1'b1;
    for (int n = 2; n <= 29; n++) begin
      p = (n - 1) % 14;
      push(1, c + n, p <= 7 ? p : 14 - p);
    end
    qc1.push_back(c + 15);
    qc1.push_back(c + 29);
    wait_cyc(c + 1); chk("u1_phase_rise", int'(phase1), 1);
    wait_cyc(c + 7); chk("u1_duty_6a", int'(duty1), 6);
    wait_cyc(c + 8); chk("u1_duty_7", int'(duty1), 7); chk("u1_no_hold", int'(phase1), 3);
    wait_cyc(c + 9); chk("u1_duty_6b", int'(duty1), 6);
    wait_cyc(c + 29); chk("u1_period_phase", int'(phase1), 1);
    en1 = 1'b0;
    wait_cyc(c + 32); chk("u1_stop_phase", int'(phase1), 0); chk("u1_stop_duty", int'(duty1), 0);
    corner_done = 1'b1;
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
